score_nibble_sched: RTL and testbench
=====================================

Name: score_nibble_sched

Overview:
- Shared-adder sequencer for the game score. One 4-bit ripple adder (`adder8`) serves two requesters: step reward (add) and miss penalty (subtract).
- Each request is processed nibble-serially over WIDTH/4 cycles, with carry chained through a register.
- The result saturates at 0 and at all-ones, and is committed to the score register. The block sits between game FSM and score display.

Parameters:
- WIDTH, 16, score width in bits; must be a multiple of 4; NIB = WIDTH/4.
- OPW, 8, requester operand width in bits; OPW <= WIDTH; zero-extended to WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- clr  in  1  pulse: clear score and sat.
- req0  in  1  requester 0 (add) request; held until ack0.
- val0  in  OPW  requester 0 operand; stable while req0 high.
- req1  in  1  requester 1 (subtract) request; held until ack1.
- val1  in  OPW  requester 1 operand; stable while req1 high.
- ack0  out  1  one-cycle pulse: requester 0 operation committed.
- ack1  out  1  one-cycle pulse: requester 1 operation committed.
- busy  out  1  high while an operation is in RUN.
- score  out  WIDTH  committed score.
- sat  out  1  sticky; set when any commit saturated.

Behaviour:
- Reset (async, reset=1): score=0, sat=0, busy=0, ack0=ack1=0, state=IDLE, nib_idx=0, carry=0, clr_pend=0, last_grant=1 (requester 0 wins the first tie).
- States: IDLE, RUN.
- IDLE priority order per edge:
  1. clr or clr_pend: score<=0, sat<=0, clr_pend<=0; no grant this edge.
  2. Otherwise, arbitrate eligible requests. reqN is eligible only if ackN is not currently high (masks the held request on the edge after its ack).
  3. One eligible request: grant it. Both eligible: grant the one != last_grant (round-robin).
- On grant:
  - Latch zero-extended operand into opnd, latch op (sub = grant==1), set last_grant.
  - carry<=sub, nib_idx<=0, res<=0, busy<=1, state<=RUN.
- RUN, each edge, adder inputs:
  - A = score[4i+3:4i], with i = nib_idx.
  - B = opnd nibble i, bitwise inverted when sub.
  - Cin = carry.
- RUN updates: res nibble i <= S, carry<=Cout, nib_idx<=nib_idx+1.
- On the edge with nib_idx==NIB-1:
  - Add: final Cout=1 → score<=all-ones, sat<=1; else score<={S,res lower}.
  - Sub: final Cout=0 (borrow) → score<=0, sat<=1; else score<=result.
  - Assert ackN (registered, one cycle), busy<=0, state<=IDLE.
- Latency: grant edge E0; commit and ack at edge E0+NIB; next grant earliest at E0+NIB+1.
- clr asserted while in RUN sets clr_pend. The clear then executes on the first IDLE edge, after the in-flight commit; the in-flight op is not aborted.
- score is stable during RUN; the shadow res holds partial sums.
- Adder ovfl output is unused; saturation is unsigned only.
- Reset mid-RUN aborts with no ack, and score returns to 0.
- Operand zero-extension: nibbles at or above OPW/4 have B=0 (add) or B=0xF (sub).

Decomposition:
- Shared package holds:
  - State enum {IDLE, RUN}.
  - Constants NIB_W = clog2(NIB), REQ_ADD=0, REQ_SUB=1.
- One sub-module instance: existing `adder8` (A, B, Cin, S, ovfl, Cout), time-shared.
- Nibble mux, inversion and saturation logic stay inline.

Test Plan (WIDTH=16, OPW=8):
- Reset, then req0 with val0=0x25 → busy high for 4 cycles; ack0 pulses once at E0+4; score=0x0025, sat=0.
- Carry propagation: score=0x00FF, req0 with val0=0x01 → score=0x0100 after 4 cycles, sat=0.
- Subtract clamp: score=0x0003, req1 with val1=0x05 → score=0x0000, sat=1, ack1 pulse. Then clr → sat=0.
- Add saturation: score=0xFFF0, req0 with val0=0x20 → score=0xFFFF, sat=1. Then req1 with val1=0x0F → score=0xFFF0.
- Contention: req0 and req1 both high from reset (val0=0x10, val1=0x04) → requester 0 served first (score=0x0010). Requester 1 is granted at the edge after ack0 (score=0x000C). ack pulses never overlap.
- Reset mid-RUN: assert reset during nibble 2 of req0 with val0=0x30 → immediately score=0, busy=0, no ack0. After release, the held req0 completes normally. Also, clr pulsed mid-RUN → score=0 one edge after that op's ack.

Source files
------------

// File: rtl/score_nibble_sched_pkg.sv
// Shared types and constants for the nibble-serial score sequencer.
package score_nibble_sched_pkg;

    typedef enum logic {
        StIdle,
        StRun
    } state_e;

    localparam logic REQ_ADD = 1'b0;
    localparam logic REQ_SUB = 1'b1;

    // Nibble index width; kept at least 1 bit so a single-nibble score still has an index.
    function automatic int unsigned nib_w(input int unsigned nib);
        return (nib > 1) ? $clog2(nib) : 1;
    endfunction

endpackage

// File: rtl/score_nibble_sched_adder8.sv
// 4-bit ripple-carry adder (legacy name adder8), time-shared across score nibbles.
module adder8 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       ovfl,
    output logic       cout
);

    logic [4:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < 4; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
        cout = c[4];
        ovfl = c[4] ^ c[3];
    end

endmodule

// File: rtl/score_nibble_sched.sv
// Two-requester score updater: add (req0) / subtract (req1) one nibble per cycle
// through a single shared 4-bit adder, with unsigned saturation on commit.
module score_nibble_sched
    import score_nibble_sched_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned OPW   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             req0,
    input  logic [OPW-1:0]   val0,
    input  logic             req1,
    input  logic [OPW-1:0]   val1,
    output logic             ack0,
    output logic             ack1,
    output logic             busy,
    output logic [WIDTH-1:0] score,
    output logic             sat
);

    localparam int unsigned NIB   = WIDTH / 4;
    localparam int unsigned NIB_W = nib_w(NIB);
    localparam logic [NIB_W-1:0] LAST_NIB = NIB_W'(NIB - 1);

    state_e             state;
    logic [NIB_W-1:0]   nib_idx;
    logic               carry;
    logic               clr_pend;
    logic               last_grant;
    logic               sub;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   res;

    logic [NIB_W+1:0]   shamt;
    logic [3:0]         a_nib;
    logic [3:0]         b_nib;
    logic [3:0]         sum;
    logic               cout;
    logic               unused_ovfl;
    logic [WIDTH-1:0]   res_next;
    logic               elig0;
    logic               elig1;
    logic               gnt;

    always_comb begin
        shamt    = {nib_idx, 2'b00};
        a_nib    = 4'(score >> shamt);
        b_nib    = 4'(opnd >> shamt) ^ {4{sub}};
        res_next = res | (WIDTH'(sum) << shamt);
        // A request is masked on the edge its ack is still visible, so a held req is not re-granted.
        elig0    = req0 & ~ack0;
        elig1    = req1 & ~ack1;
        gnt      = (elig0 & elig1) ? ~last_grant : elig1;
    end

    adder8 u_adder (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry),
        .s    (sum),
        .ovfl (unused_ovfl),
        .cout (cout)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= StIdle;
            nib_idx    <= '0;
            carry      <= 1'b0;
            clr_pend   <= 1'b0;
            last_grant <= 1'b1;
            sub        <= REQ_ADD;
            opnd       <= '0;
            res        <= '0;
            score      <= '0;
            sat        <= 1'b0;
            busy       <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                StIdle: begin
                    if (clr || clr_pend) begin
                        score    <= '0;
                        sat      <= 1'b0;
                        clr_pend <= 1'b0;
                    end else if (elig0 || elig1) begin
                        opnd       <= WIDTH'(gnt ? val1 : val0);
                        sub        <= (gnt == REQ_SUB);
                        last_grant <= gnt;
                        carry      <= (gnt == REQ_SUB);
                        nib_idx    <= '0;
                        res        <= '0;
                        busy       <= 1'b1;
                        state      <= StRun;
                    end
                end
                StRun: begin
                    if (clr) begin
                        clr_pend <= 1'b1;
                    end
                    res     <= res_next;
                    carry   <= cout;
                    nib_idx <= nib_idx + 1'b1;
                    if (nib_idx == LAST_NIB) begin
                        // Add carry-out means overflow; subtract without carry-out means borrow.
                        if (!sub && cout) begin
                            score <= '1;
                            sat   <= 1'b1;
                        end else if (sub && !cout) begin
                            score <= '0;
                            sat   <= 1'b1;
                        end else begin
                            score <= res_next;
                        end
                        ack0    <= ~sub;
                        ack1    <= sub;
                        busy    <= 1'b0;
                        nib_idx <= '0;
                        state   <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_score_nibble_sched.sv
// Randomized and directed bench for score_nibble_sched against an arithmetic reference model.
module tb_score_nibble_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clr = 1'b0;
    logic        req0 = 1'b0;
    logic [7:0]  val0 = '0;
    logic        req1 = 1'b0;
    logic [7:0]  val1 = '0;
    logic        ack0;
    logic        ack1;
    logic        busy;
    logic [15:0] score;
    logic        sat;

    int total = 0;
    int bad = 0;

    score_nibble_sched #(
        .WIDTH (16),
        .OPW   (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .req0  (req0),
        .val0  (val0),
        .req1  (req1),
        .val1  (val1),
        .ack0  (ack0),
        .ack1  (ack1),
        .busy  (busy),
        .score (score),
        .sat   (sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: whole-value unsigned arithmetic with clamping, fixed NIB-cycle latency.
    int m_score = 0;
    int m_cnt = 0;
    int m_val = 0;
    bit m_sat = 0, m_busy = 0, m_ack0 = 0, m_ack1 = 0, m_clrp = 0, m_last = 1, m_op = 0;

    initial begin
        int r;
        bit a0, a1, e0, e1, g;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_score = 0; m_sat = 0; m_busy = 0; m_ack0 = 0; m_ack1 = 0;
                m_clrp = 0; m_last = 1; m_cnt = 0;
            end else begin
                a0 = m_ack0;
                a1 = m_ack1;
                m_ack0 = 0;
                m_ack1 = 0;
                if (m_busy) begin
                    if (clr) m_clrp = 1;
                    m_cnt--;
                    if (m_cnt == 0) begin
                        r = m_op ? m_score - m_val : m_score + m_val;
                        if (r > 65535) begin r = 65535; m_sat = 1; end
                        if (r < 0) begin r = 0; m_sat = 1; end
                        m_score = r;
                        m_busy = 0;
                        if (m_op) m_ack1 = 1; else m_ack0 = 1;
                    end
                end else if (clr || m_clrp) begin
                    m_score = 0; m_sat = 0; m_clrp = 0;
                end else begin
                    e0 = req0 && !a0;
                    e1 = req1 && !a1;
                    if (e0 || e1) begin
                        g = (e0 && e1) ? !m_last : e1;
                        m_op = g;
                        m_last = g;
                        m_val = g ? int'(val1) : int'(val0);
                        m_busy = 1;
                        m_cnt = 4;
                    end
                end
            end
        end
    end

    // Cycle-by-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(negedge clk);
            chk("score", int'(score), m_score);
            chk("sat", int'(sat), int'(m_sat));
            chk("busy", int'(busy), int'(m_busy));
            chk("ack0", int'(ack0), int'(m_ack0));
            chk("ack1", int'(ack1), int'(m_ack1));
            chk("ack_overlap", int'(ack0 & ack1), 0);
        end
    end

    task automatic wait_ack(input bit which, output int cyc);
        bit got;
        got = 0;
        cyc = 0;
        for (int n = 0; n < 60 && !got; n++) begin
            @(negedge clk);
            cyc++;
            if (which ? ack1 : ack0) got = 1;
        end
        if (!got) chk("ack_timeout", 0, 1);
    endtask

    task automatic wait_busy();
        bit got;
        got = 0;
        for (int n = 0; n < 60 && !got; n++) begin
            @(negedge clk);
            if (busy) got = 1;
        end
        if (!got) chk("busy_timeout", 0, 1);
    endtask

    // Called at a negedge; returns at the negedge where the ack is visible, with req dropped.
    task automatic do_op(input bit which, input logic [7:0] v, output int bcyc);
        bit got;
        got = 0;
        bcyc = 0;
        if (which) begin req1 = 1; val1 = v; end
        else begin req0 = 1; val0 = v; end
        for (int n = 0; n < 60 && !got; n++) begin
            @(negedge clk);
            if (busy) bcyc++;
            if (which ? ack1 : ack0) got = 1;
        end
        if (which) req1 = 0; else req0 = 0;
        if (!got) chk("ack_timeout", 0, 1);
    endtask

    task automatic clr_pulse();
        clr = 1;
        @(negedge clk);
        clr = 0;
    endtask

    initial begin
        int bc;
        int cyc;
        repeat (2) @(negedge clk);
        reset = 0;
        @(negedge clk);
        chk("reset_score", int'(score), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_sat", int'(sat), 0);

        do_op(0, 8'h25, bc);
        chk("add_busy_cycles", bc, 4);
        chk("add_score", int'(score), 'h0025);
        chk("add_sat", int'(sat), 0);
        @(negedge clk);
        chk("ack0_single_pulse", int'(ack0), 0);

        clr_pulse();
        do_op(0, 8'hFF, bc);
        do_op(0, 8'h01, bc);
        chk("carry_score", int'(score), 'h0100);
        chk("carry_sat", int'(sat), 0);

        clr_pulse();
        do_op(0, 8'h03, bc);
        do_op(1, 8'h05, bc);
        chk("sub_clamp_score", int'(score), 0);
        chk("sub_clamp_sat", int'(sat), 1);
        clr_pulse();
        chk("clr_sat", int'(sat), 0);

        for (int i = 0; i < 257; i++) do_op(0, 8'hFF, bc);
        chk("fill_score", int'(score), 'hFFFF);
        chk("fill_sat", int'(sat), 0);
        do_op(1, 8'h0F, bc);
        chk("fff0_score", int'(score), 'hFFF0);
        do_op(0, 8'h20, bc);
        chk("add_sat_score", int'(score), 'hFFFF);
        chk("add_sat_flag", int'(sat), 1);
        do_op(1, 8'h0F, bc);
        chk("after_sat_sub", int'(score), 'hFFF0);

        // Contention from reset: requester 0 first, requester 1 on the edge after ack0.
        reset = 1;
        req0 = 1; val0 = 8'h10;
        req1 = 1; val1 = 8'h04;
        @(negedge clk);
        reset = 0;
        wait_ack(0, cyc);
        chk("contend_first", int'(score), 'h0010);
        req0 = 0;
        wait_ack(1, cyc);
        chk("contend_gap", cyc, 5);
        chk("contend_second", int'(score), 'h000C);
        req1 = 0;

        // Reset during nibble 2 of an add, then the held request finishes.
        do_op(0, 8'h11, bc);
        req0 = 1; val0 = 8'h30;
        wait_busy();
        repeat (2) @(negedge clk);
        #2 reset = 1;
        #1;
        chk("midrun_reset_score", int'(score), 0);
        chk("midrun_reset_busy", int'(busy), 0);
        chk("midrun_reset_ack0", int'(ack0), 0);
        @(negedge clk);
        reset = 0;
        wait_ack(0, cyc);
        chk("after_reset_score", int'(score), 'h0030);
        req0 = 0;

        // clr during RUN: commit first, clear on the following edge.
        req0 = 1; val0 = 8'h05;
        wait_busy();
        clr_pulse();
        wait_ack(0, cyc);
        chk("clr_pend_commit", int'(score), 'h0035);
        req0 = 0;
        @(negedge clk);
        chk("clr_pend_clear", int'(score), 0);

        for (int c = 0; c < 3000; c++) begin
            if (req0) begin
                if (ack0) begin
                    if ($urandom_range(1, 0) == 1) req0 = 0;
                    else val0 = 8'($urandom);
                end
            end else if ($urandom_range(2, 0) == 0) begin
                req0 = 1; val0 = 8'($urandom);
            end
            if (req1) begin
                if (ack1) begin
                    if ($urandom_range(1, 0) == 1) req1 = 0;
                    else val1 = 8'($urandom);
                end
            end else if ($urandom_range(2, 0) == 0) begin
                req1 = 1; val1 = 8'($urandom);
            end
            clr = ($urandom_range(49, 0) == 0);
            @(negedge clk);
        end
        req0 = 0; req1 = 0; clr = 0;
        repeat (12) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
